// File: rtl/counter_sweep_if.sv
// Control and status bundle for the sweep sequencer: run request, limits,
// and the count/status observed by display and test logic.
interface counter_sweep_if #(
   parameter int N    = 4,
   parameter int SW_W = 4
);
   logic            start;
   logic            abort;
   logic [N-1:0]    lo;
   logic [N-1:0]    hi;
   logic [SW_W-1:0] sweeps;
   logic [N-1:0]    count;
   logic            up_down;
   logic            busy;
   logic            at_limit;
   logic            done;
   logic            err;
   logic [SW_W-1:0] sweeps_done;

   modport master (
      output start, abort, lo, hi, sweeps,
      input  count, up_down, busy, at_limit, done, err, sweeps_done
   );

   modport slave (
      input  start, abort, lo, hi, sweeps,
      output count, up_down, busy, at_limit, done, err, sweeps_done
   );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Triangular sweep sequencer over an N-bit up/down count: lo->hi->lo sweeps
// with a dwell at each limit, start/abort control and completion pulses.
module counter_sweep_ctrl #(
   parameter int N     = 4,
   parameter int DWELL = 2,
   parameter int SW_W  = 4
) (
   input logic             clk,
   input logic             reset,
   counter_sweep_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, UP, TOP, DOWN, BOT} state_t;

   localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

   state_t          state_q, state_d;
   logic [N-1:0]    count_q, count_d;
   logic [N-1:0]    lo_q, lo_d;
   logic [N-1:0]    hi_q, hi_d;
   logic [SW_W-1:0] sw_q, sw_d;
   logic [SW_W-1:0] sd_q, sd_d;
   logic [SW_W-1:0] sd_inc;
   logic [3:0]      dwell_q, dwell_d;
   logic            up_q, up_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   assign sd_inc = sd_q + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         sw_q    <= '0;
         sd_q    <= '0;
         dwell_q <= '0;
         up_q    <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         sw_q    <= sw_d;
         sd_q    <= sd_d;
         dwell_q <= dwell_d;
         up_q    <= up_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      sw_d    = sw_q;
      sd_d    = sd_q;
      dwell_d = dwell_q;
      up_d    = up_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      if (state_q != IDLE && bus.abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  if (bus.lo < bus.hi && bus.sweeps != '0) begin
                     // The skipped initial bottom dwell is folded in: go straight to UP at lo.
                     lo_d    = bus.lo;
                     hi_d    = bus.hi;
                     sw_d    = bus.sweeps;
                     count_d = bus.lo;
                     sd_d    = '0;
                     dwell_d = DWELL_LAST;
                     up_d    = 1'b1;
                     state_d = UP;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            UP: begin
               if (count_q != hi_q) begin
                  count_d = count_q + 1'b1;
               end else begin
                  dwell_d = DWELL_LAST;
                  state_d = TOP;
               end
            end
            TOP: begin
               if (dwell_q == '0) begin
                  count_d = hi_q - 1'b1;
                  up_d    = 1'b0;
                  state_d = DOWN;
               end else begin
                  dwell_d = dwell_q - 1'b1;
               end
            end
            DOWN: begin
               if (count_q != lo_q) begin
                  count_d = count_q - 1'b1;
               end else begin
                  dwell_d = DWELL_LAST;
                  state_d = BOT;
               end
            end
            BOT: begin
               if (dwell_q == '0) begin
                  sd_d = sd_inc;
                  if (sd_inc == sw_q) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     count_d = lo_q + 1'b1;
                     up_d    = 1'b1;
                     state_d = UP;
                  end
               end else begin
                  dwell_d = dwell_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.count       = count_q;
   assign bus.up_down     = up_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.at_limit    = (state_q != IDLE) && (count_q == lo_q || count_q == hi_q);
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.sweeps_done = sd_q;
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl: reset, sweeps, rejects, abort,
// mid-run input immunity and asynchronous reset during a run.
module tb_counter_sweep_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   counter_sweep_if #(.N(4), .SW_W(4)) bus ();

   counter_sweep_ctrl #(.N(4), .DWELL(2), .SW_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int l, input int h, input int s);
      bus.lo = 4'(l); bus.hi = 4'(h); bus.sweeps = 4'(s); bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      total_cnt++; if (bus.count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else pass_cnt++;
      total_cnt++; if (bus.up_down !== 1'b1) $display("FAIL reset_up_down got=%b exp=1", bus.up_down); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.at_limit !== 1'b0) $display("FAIL reset_at_limit got=%b exp=0", bus.at_limit); else pass_cnt++;
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else pass_cnt++;
      total_cnt++; if (bus.err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.err); else pass_cnt++;
      total_cnt++; if (bus.sweeps_done !== 4'd0) $display("FAIL reset_sweeps_done got=%0d exp=0", bus.sweeps_done); else pass_cnt++;
   endtask

   task automatic test_single_sweep();
      int exp_c[11];
      int exp_d[11];
      int exp_l[11];
      exp_c = '{2, 3, 4, 5, 5, 5, 4, 3, 2, 2, 2};
      exp_d = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
      exp_l = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
      launch(2, 5, 1);
      for (int i = 0; i < 11; i++) begin
         total_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy[%0d] got=%b exp=1", i, bus.busy); else pass_cnt++;
         total_cnt++; if (bus.count !== 4'(exp_c[i])) $display("FAIL single_count[%0d] got=%0d exp=%0d", i, bus.count, exp_c[i]); else pass_cnt++;
         total_cnt++; if (bus.up_down !== 1'(exp_d[i])) $display("FAIL single_up_down[%0d] got=%b exp=%0d", i, bus.up_down, exp_d[i]); else pass_cnt++;
         total_cnt++; if (bus.at_limit !== 1'(exp_l[i])) $display("FAIL single_at_limit[%0d] got=%b exp=%0d", i, bus.at_limit, exp_l[i]); else pass_cnt++;
         total_cnt++; if (bus.done !== 1'b0) $display("FAIL single_early_done[%0d] got=%b exp=0", i, bus.done); else pass_cnt++;
         step();
      end
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_end_busy got=%b exp=0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.done !== 1'b1) $display("FAIL single_done got=%b exp=1", bus.done); else pass_cnt++;
      total_cnt++; if (bus.sweeps_done !== 4'd1) $display("FAIL single_sweeps_done got=%0d exp=1", bus.sweeps_done); else pass_cnt++;
      total_cnt++; if (bus.count !== 4'd2) $display("FAIL single_end_count got=%0d exp=2", bus.count); else pass_cnt++;
      total_cnt++; if (bus.at_limit !== 1'b0) $display("FAIL single_idle_at_limit got=%b exp=0", bus.at_limit); else pass_cnt++;
      step();
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL single_done_width got=%b exp=0", bus.done); else pass_cnt++;
   endtask

   task automatic test_multi_sweep();
      int seen[200];
      int cyc = 0;
      int jumps = 0;
      int dones = 0;
      launch(0, 15, 2);
      while (bus.busy === 1'b1 && cyc < 200) begin
         seen[cyc] = int'(bus.count);
         if (cyc > 0 && (seen[cyc] - seen[cyc-1] > 1 || seen[cyc-1] - seen[cyc] > 1)) jumps++;
         if (bus.done === 1'b1) dones++;
         cyc++;
         step();
      end
      total_cnt++; if (cyc !== 69) $display("FAIL multi_busy_cycles got=%0d exp=69", cyc); else pass_cnt++;
      total_cnt++; if (jumps !== 0) $display("FAIL multi_wrap_jumps got=%0d exp=0", jumps); else pass_cnt++;
      total_cnt++; if (dones !== 0) $display("FAIL multi_done_while_busy got=%0d exp=0", dones); else pass_cnt++;
      if (cyc == 69) begin
         total_cnt++; if (seen[0] !== 0) $display("FAIL multi_first got=%0d exp=0", seen[0]); else pass_cnt++;
         total_cnt++; if (seen[17] !== 15) $display("FAIL multi_top_dwell got=%0d exp=15", seen[17]); else pass_cnt++;
         total_cnt++; if (seen[18] !== 14) $display("FAIL multi_first_down got=%0d exp=14", seen[18]); else pass_cnt++;
         total_cnt++; if (seen[34] !== 0) $display("FAIL multi_bot_dwell got=%0d exp=0", seen[34]); else pass_cnt++;
         total_cnt++; if (seen[35] !== 1) $display("FAIL multi_second_start got=%0d exp=1", seen[35]); else pass_cnt++;
         total_cnt++; if (seen[49] !== 15) $display("FAIL multi_second_top got=%0d exp=15", seen[49]); else pass_cnt++;
      end
      total_cnt++; if (bus.done !== 1'b1) $display("FAIL multi_done got=%b exp=1", bus.done); else pass_cnt++;
      total_cnt++; if (bus.sweeps_done !== 4'd2) $display("FAIL multi_sweeps_done got=%0d exp=2", bus.sweeps_done); else pass_cnt++;
      total_cnt++; if (bus.count !== 4'd0) $display("FAIL multi_end_count got=%0d exp=0", bus.count); else pass_cnt++;
      step();
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL multi_done_width got=%b exp=0", bus.done); else pass_cnt++;
   endtask

   task automatic test_rejects();
      launch(5, 5, 1);
      total_cnt++; if (bus.err !== 1'b1) $display("FAIL rej_eq_err got=%b exp=1", bus.err); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rej_eq_busy got=%b exp=0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.count !== 4'd0) $display("FAIL rej_eq_count got=%0d exp=0", bus.count); else pass_cnt++;
      total_cnt++; if (bus.sweeps_done !== 4'd2) $display("FAIL rej_eq_sweeps_done got=%0d exp=2", bus.sweeps_done); else pass_cnt++;
      step();
      total_cnt++; if (bus.err !== 1'b0) $display("FAIL rej_eq_err_width got=%b exp=0", bus.err); else pass_cnt++;
      launch(2, 5, 0);
      total_cnt++; if (bus.err !== 1'b1) $display("FAIL rej_zero_err got=%b exp=1", bus.err); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rej_zero_busy got=%b exp=0", bus.busy); else pass_cnt++;
      step();
      total_cnt++; if (bus.err !== 1'b0) $display("FAIL rej_zero_err_width got=%b exp=0", bus.err); else pass_cnt++;
      bus.abort = 1'b1;
      launch(2, 5, 1);
      bus.abort = 1'b0;
      total_cnt++; if (bus.err !== 1'b0) $display("FAIL start_abort_err got=%b exp=0", bus.err); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL start_abort_busy got=%b exp=0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.count !== 4'd0) $display("FAIL start_abort_count got=%0d exp=0", bus.count); else pass_cnt++;
   endtask

   task automatic test_abort();
      int cyc = 0;
      int dones = 0;
      launch(2, 5, 1);
      for (int i = 0; i < 4; i++) step();
      total_cnt++; if (bus.count !== 4'd5) $display("FAIL abort_pre_count got=%0d exp=5", bus.count); else pass_cnt++;
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.count !== 4'd5) $display("FAIL abort_count got=%0d exp=5", bus.count); else pass_cnt++;
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL abort_done got=%b exp=0", bus.done); else pass_cnt++;
      total_cnt++; if (bus.at_limit !== 1'b0) $display("FAIL abort_at_limit got=%b exp=0", bus.at_limit); else pass_cnt++;
      total_cnt++; if (bus.up_down !== 1'b1) $display("FAIL abort_up_down got=%b exp=1", bus.up_down); else pass_cnt++;
      total_cnt++; if (bus.sweeps_done !== 4'd0) $display("FAIL abort_sweeps_done got=%0d exp=0", bus.sweeps_done); else pass_cnt++;
      step();
      total_cnt++; if (bus.done !== 1'b0) $display("FAIL abort_late_done got=%b exp=0", bus.done); else pass_cnt++;
      launch(1, 3, 1);
      total_cnt++; if (bus.count !== 4'd1) $display("FAIL restart_first got=%0d exp=1", bus.count); else pass_cnt++;
      while (bus.busy === 1'b1 && cyc < 50) begin
         if (bus.done === 1'b1) dones++;
         cyc++;
         step();
      end
      total_cnt++; if (cyc !== 9) $display("FAIL restart_busy_cycles got=%0d exp=9", cyc); else pass_cnt++;
      total_cnt++; if (dones !== 0) $display("FAIL restart_done_while_busy got=%0d exp=0", dones); else pass_cnt++;
      total_cnt++; if (bus.done !== 1'b1) $display("FAIL restart_done got=%b exp=1", bus.done); else pass_cnt++;
      total_cnt++; if (bus.count !== 4'd1) $display("FAIL restart_end_count got=%0d exp=1", bus.count); else pass_cnt++;
      total_cnt++; if (bus.sweeps_done !== 4'd1) $display("FAIL restart_sweeps_done got=%0d exp=1", bus.sweeps_done); else pass_cnt++;
   endtask

   task automatic test_busy_immunity();
      int exp_c[11];
      int exp_l[11];
      exp_c = '{2, 3, 4, 5, 5, 5, 4, 3, 2, 2, 2};
      exp_l = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
      launch(2, 5, 1);
      for (int i = 0; i < 11; i++) begin
         if (i == 3) begin
            bus.start = 1'b1; bus.lo = 4'd0; bus.hi = 4'd9; bus.sweeps = 4'd3;
         end
         if (i == 5) bus.start = 1'b0;
         total_cnt++; if (bus.count !== 4'(exp_c[i])) $display("FAIL immune_count[%0d] got=%0d exp=%0d", i, bus.count, exp_c[i]); else pass_cnt++;
         total_cnt++; if (bus.at_limit !== 1'(exp_l[i])) $display("FAIL immune_at_limit[%0d] got=%b exp=%0d", i, bus.at_limit, exp_l[i]); else pass_cnt++;
         step();
      end
      bus.start = 1'b0; bus.lo = 4'd2; bus.hi = 4'd5; bus.sweeps = 4'd1;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL immune_end_busy got=%b exp=0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.done !== 1'b1) $display("FAIL immune_done got=%b exp=1", bus.done); else pass_cnt++;
      total_cnt++; if (bus.sweeps_done !== 4'd1) $display("FAIL immune_sweeps_done got=%0d exp=1", bus.sweeps_done); else pass_cnt++;
   endtask

   task automatic test_reset_midrun();
      int dones = 0;
      int busies = 0;
      step();
      launch(2, 5, 1);
      for (int i = 0; i < 7; i++) step();
      total_cnt++; if (bus.up_down !== 1'b0) $display("FAIL midrun_pre_dir got=%b exp=0", bus.up_down); else pass_cnt++;
      #2 reset = 1'b0;
      #1;
      total_cnt++; if (bus.count !== 4'd0) $display("FAIL midrun_count got=%0d exp=0", bus.count); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL midrun_busy got=%b exp=0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.up_down !== 1'b1) $display("FAIL midrun_up_down got=%b exp=1", bus.up_down); else pass_cnt++;
      total_cnt++; if (bus.sweeps_done !== 4'd0) $display("FAIL midrun_sweeps_done got=%0d exp=0", bus.sweeps_done); else pass_cnt++;
      #2 reset = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         if (bus.done === 1'b1) dones++;
         if (bus.busy === 1'b1) busies++;
      end
      total_cnt++; if (dones !== 0) $display("FAIL midrun_late_done got=%0d exp=0", dones); else pass_cnt++;
      total_cnt++; if (busies !== 0) $display("FAIL midrun_late_busy got=%0d exp=0", busies); else pass_cnt++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0;
      bus.lo = 4'd0; bus.hi = 4'd0; bus.sweeps = 4'd0;
      #12;
      test_reset();
      reset = 1'b1;
      step();
      test_single_sweep();
      test_multi_sweep();
      test_rejects();
      test_abort();
      step();
      test_busy_immunity();
      test_reset_midrun();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
